// File: rtl/axis_traffic_pkg.sv
// Shared types, error codes and header layout for the AXI-Stream traffic checker.
// The packet header carries a 32-bit sequence number followed by a 16-bit length, both little-endian.
package axis_traffic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BODY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_KEEP_GAP  = 3'd1;
  localparam logic [2:0] ERR_KEEP_PART = 3'd2;
  localparam logic [2:0] ERR_LEN       = 3'd3;
  localparam logic [2:0] ERR_SEQ       = 3'd4;
  localparam logic [2:0] ERR_PAYLOAD   = 3'd5;
  localparam logic [2:0] ERR_BYTECNT   = 3'd6;

  localparam int HDR_BYTES = 6;
  localparam int SEQ_OFS   = 0;
  localparam int LEN_OFS   = 4;

  // Lower code number wins; ERR_NONE never overrides a real cause.
  function automatic logic [2:0] err_merge(input logic [2:0] a, input logic [2:0] b);
    if (a == ERR_NONE) return b;
    if (b == ERR_NONE) return a;
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/axis_traffic_checker_keep_decode.sv
// Combinational tkeep decode: contiguity from lane 0, all-ones flag and enabled-byte count.
// An all-zero mask counts as contiguous.
module axis_keep_decode #(
  parameter int BYTES = 64,
  parameter int CNT_W = $clog2(BYTES + 1)
) (
  input  logic [BYTES-1:0] keep,
  output logic             contiguous,
  output logic             all_ones,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int j = 0; j < BYTES; j++) begin
      count = count + CNT_W'(keep[j]);
    end
  end

  assign contiguous = ((keep & (keep + BYTES'(1))) == '0);
  assign all_ones   = &keep;

endmodule

// File: rtl/axis_traffic_checker.sv
// Receive-side traffic checker: validates header, byte pattern, framing and sequence of each packet
// and issues a single pass/fail verdict once the sender is done and the link has been quiet.
//
//   state | meaning
//   IDLE  | waiting for a header beat
//   BODY  | inside a multi-beat packet
//   DRAIN | sender done; counting quiet cycles, a valid beat is treated as a header
//   DONE  | verdict valid, beats ignored until rst
module axis_traffic_checker
  import axis_traffic_pkg::*;
#(
  parameter int DWIDTH       = 512,
  parameter int EXP_PKTS     = 1000,
  parameter int IDLE_TIMEOUT = 256,
  parameter int CNT_WIDTH    = 32,
  parameter int MAX_LEN      = 9600
) (
  input  logic                  bus_clk,
  input  logic                  rst,
  input  logic [DWIDTH-1:0]     s_axis_tdata,
  input  logic [DWIDTH/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  input  logic                  remote_send_done,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [2:0]            first_err_code,
  output logic                  check_result,
  output logic                  check_result_valid
);

  localparam int BYTES = DWIDTH / 8;
  localparam int KCW   = $clog2(BYTES + 1);
  localparam int QW    = $clog2(IDLE_TIMEOUT + 1);

  chk_state_t state_q, state_d;
  logic [QW-1:0] quiet_q;
  logic          quiet_tc;

  logic [31:0] exp_seq_q;
  logic [15:0] len_q;
  logic [15:0] bytes_q;
  logic [7:0]  base_q;

  logic           s1_valid, s1_hdr, s1_last;
  logic [2:0]     s1_code;
  logic [2:0]     pkt_code_q, pkt_code_d;

  logic           keep_contig, keep_all;
  logic [KCW-1:0] keep_cnt;

  logic        accept, hdr;
  logic [15:0] rx_len, cnt_sum;
  logic [31:0] hdr_seq;
  logic [7:0]  base;
  logic        pay_bad;
  logic [2:0]  beat_code;

  axis_keep_decode #(.BYTES(BYTES), .CNT_W(KCW)) u_keep_decode (
    .keep       (s_axis_tkeep),
    .contiguous (keep_contig),
    .all_ones   (keep_all),
    .count      (keep_cnt)
  );

  assign accept  = s_axis_tvalid && (state_q != DONE);
  assign hdr     = accept && ((state_q == IDLE) || (state_q == DRAIN));
  assign hdr_seq = s_axis_tdata[8*SEQ_OFS +: 32];
  assign rx_len  = hdr ? s_axis_tdata[8*LEN_OFS +: 16] : len_q;
  assign base    = hdr ? hdr_seq[7:0] : base_q;
  assign cnt_sum = (hdr ? 16'd0 : bytes_q) + 16'(keep_cnt);

  always_comb begin
    pay_bad = 1'b0;
    for (int j = 0; j < BYTES; j++) begin
      if (s_axis_tkeep[j] && !(hdr && (j < HDR_BYTES)) &&
          (s_axis_tdata[8*j +: 8] != 8'(base + 8'(j))))
        pay_bad = 1'b1;
    end
    beat_code = ERR_NONE;
    if (!keep_contig)                                                      beat_code = ERR_KEEP_GAP;
    else if (!s_axis_tlast && !keep_all)                                   beat_code = ERR_KEEP_PART;
    else if (hdr && (rx_len < 16'(HDR_BYTES) || rx_len > 16'(MAX_LEN)))    beat_code = ERR_LEN;
    else if (hdr && (hdr_seq != exp_seq_q))                                beat_code = ERR_SEQ;
    else if (pay_bad)                                                      beat_code = ERR_PAYLOAD;
    else if (s_axis_tlast && (cnt_sum != rx_len))                          beat_code = ERR_BYTECNT;
  end

  always_ff @(posedge bus_clk) begin
    if (rst) begin
      exp_seq_q <= '0;
      len_q     <= '0;
      bytes_q   <= '0;
      base_q    <= '0;
      s1_valid  <= 1'b0;
      s1_hdr    <= 1'b0;
      s1_last   <= 1'b0;
      s1_code   <= ERR_NONE;
    end else begin
      s1_valid <= accept;
      s1_hdr   <= hdr;
      s1_last  <= s_axis_tlast;
      s1_code  <= beat_code;
      if (accept) begin
        len_q   <= rx_len;
        bytes_q <= cnt_sum;
        base_q  <= base + 8'(BYTES);
      end
      // A mismatching SEQ still resynchronises the expectation.
      if (hdr) exp_seq_q <= hdr_seq + 32'd1;
    end
  end

  assign pkt_code_d = err_merge(s1_hdr ? ERR_NONE : pkt_code_q, s1_code);

  always_ff @(posedge bus_clk) begin
    if (rst) begin
      pkt_count      <= '0;
      err_count      <= '0;
      first_err_code <= ERR_NONE;
      pkt_code_q     <= ERR_NONE;
    end else if (s1_valid) begin
      if (s1_last) begin
        pkt_count  <= pkt_count + CNT_WIDTH'(1);
        pkt_code_q <= ERR_NONE;
        if (pkt_code_d != ERR_NONE) begin
          if (err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
          if (first_err_code == ERR_NONE) first_err_code <= pkt_code_d;
        end
      end else begin
        pkt_code_q <= pkt_code_d;
      end
    end
  end

  assign quiet_tc = (quiet_q == QW'(1));

  always_ff @(posedge bus_clk) begin
    if (rst)                                     quiet_q <= QW'(IDLE_TIMEOUT);
    else if (state_q == DRAIN && !s_axis_tvalid) quiet_q <= quiet_q - QW'(1);
    else                                         quiet_q <= QW'(IDLE_TIMEOUT);
  end

  always_ff @(posedge bus_clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (s_axis_tvalid && !s_axis_tlast) state_d = BODY;
        else if (remote_send_done)          state_d = DRAIN;
      end
      BODY: begin
        if (s_axis_tvalid && s_axis_tlast) state_d = remote_send_done ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (s_axis_tvalid) begin
          if (!s_axis_tlast)         state_d = BODY;
          else if (!remote_send_done) state_d = IDLE;
        end else if (quiet_tc) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign check_result_valid = (state_q == DONE);
  assign check_result = check_result_valid && (err_count == '0) &&
                        (pkt_count == CNT_WIDTH'(EXP_PKTS)) && (first_err_code == ERR_NONE);

endmodule

// File: tb/tb_axis_traffic_checker.sv
// Directed bench for axis_traffic_checker: clean traffic, each error code, resync, back-to-back
// single-beat packets, mid-packet reset, late remote_send_done and SEQ wrap.
module tb_axis_traffic_checker;

  localparam int DW = 512;
  localparam int BY = DW / 8;
  localparam int CW = 32;

  logic          bus_clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [BY-1:0] s_axis_tkeep = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          remote_send_done = 1'b0;
  logic [CW-1:0] pkt_count, err_count;
  logic [2:0]    first_err_code;
  logic          check_result, check_result_valid;

  int total = 0;
  int passed = 0;

  always #5 bus_clk = ~bus_clk;

  axis_traffic_checker #(
    .DWIDTH(DW), .EXP_PKTS(10), .IDLE_TIMEOUT(256), .CNT_WIDTH(CW), .MAX_LEN(9600)
  ) dut (
    .bus_clk            (bus_clk),
    .rst                (rst),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tkeep       (s_axis_tkeep),
    .s_axis_tlast       (s_axis_tlast),
    .s_axis_tvalid      (s_axis_tvalid),
    .remote_send_done   (remote_send_done),
    .pkt_count          (pkt_count),
    .err_count          (err_count),
    .first_err_code     (first_err_code),
    .check_result       (check_result),
    .check_result_valid (check_result_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    remote_send_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // Drives one packet starting right after a clock edge; ends with tvalid low so that a
  // following call in the same time step gives true back-to-back beats.
  task automatic send_pkt(input logic [31:0] seq, input int len_field, input int nbytes,
                          input int corrupt, input int keep_beat, input logic [BY-1:0] keep_val,
                          input int gap_beat, input int done_beat, input int max_beats);
    int nbeats;
    logic [7:0] v;
    logic [15:0] lf;
    nbeats = (nbytes + BY - 1) / BY;
    if (nbeats == 0) nbeats = 1;
    lf = 16'(len_field);
    for (int b = 0; b < nbeats; b++) begin
      if (max_beats >= 0 && b >= max_beats) break;
      if (b == gap_beat) idle(3);
      if (b == done_beat) remote_send_done = 1'b1;
      for (int j = 0; j < BY; j++) begin
        int idx;
        idx = b * BY + j;
        if (idx < 4)       v = seq[8*idx +: 8];
        else if (idx == 4) v = lf[7:0];
        else if (idx == 5) v = lf[15:8];
        else               v = seq[7:0] + 8'(idx);
        if (idx == corrupt) v = v ^ 8'hFF;
        s_axis_tdata[8*j +: 8] = v;
        s_axis_tkeep[j] = (idx < nbytes);
      end
      if (b == keep_beat) s_axis_tkeep = keep_val;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (b == nbeats - 1);
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic good_pkt(input logic [31:0] seq, input int len);
    send_pkt(seq, len, len, -1, -1, '0, -1, -1, -1);
  endtask

  initial begin
    int L;
    tick();
    do_reset();
    chk("rst pkt_count", pkt_count, 0);
    chk("rst err_count", err_count, 0);
    chk("rst first_err", 32'(first_err_code), 0);
    chk("rst valid", 32'(check_result_valid), 0);
    chk("rst result", 32'(check_result), 0);

    // clean run, with a tvalid gap inside packet 2
    for (int i = 0; i < 10; i++) begin
      L = 64 + 15 * i;
      send_pkt(32'(i), L, L, -1, -1, '0, (i == 2) ? 1 : -1, -1, -1);
    end
    idle(2);
    chk("clean pkt_count", pkt_count, 10);
    chk("clean err_count", err_count, 0);
    remote_send_done = 1'b1;
    idle(250);
    chk("clean early valid", 32'(check_result_valid), 0);
    idle(10);
    chk("clean valid", 32'(check_result_valid), 1);
    chk("clean result", 32'(check_result), 1);
    chk("clean first_err", 32'(first_err_code), 0);
    good_pkt(32'd77, 64);
    idle(3);
    chk("done ignores beats", pkt_count, 10);
    chk("done holds", 32'(check_result_valid), 1);

    // payload corruption in packet 3
    do_reset();
    for (int i = 0; i < 10; i++) begin
      L = 64 + 15 * i;
      send_pkt(32'(i), L, L, (i == 3) ? 100 : -1, -1, '0, -1, -1, -1);
      if (i == 4) begin
        idle(2);
        chk("pkt4 clean after corrupt", err_count, 1);
      end
    end
    remote_send_done = 1'b1;
    idle(260);
    chk("corrupt valid", 32'(check_result_valid), 1);
    chk("corrupt result", 32'(check_result), 0);
    chk("corrupt err_count", err_count, 1);
    chk("corrupt code", 32'(first_err_code), 5);
    chk("corrupt pkt_count", pkt_count, 10);

    // skipped SEQ 5, resync on 6
    do_reset();
    for (int i = 0; i < 10; i++) begin
      good_pkt(32'((i < 5) ? i : i + 1), 80);
      if (i == 6) begin
        idle(2);
        chk("resync seq7 clean", err_count, 1);
      end
    end
    idle(2);
    chk("seq code", 32'(first_err_code), 4);
    chk("seq err_count", err_count, 1);
    chk("seq pkt_count", pkt_count, 10);

    // framing / length errors
    do_reset();
    send_pkt(32'd0, 128, 128, -1, 1, {{(BY-4){1'b1}}, 4'h0}, -1, -1, -1);
    idle(2);
    chk("keep gap code", 32'(first_err_code), 1);
    chk("keep gap err_count", err_count, 1);
    do_reset();
    send_pkt(32'd0, 200, 200, -1, 1, {{(BY-48){1'b0}}, {48{1'b1}}}, -1, -1, -1);
    idle(2);
    chk("keep partial code", 32'(first_err_code), 2);
    do_reset();
    send_pkt(32'd0, 5, 6, -1, -1, '0, -1, -1, -1);
    idle(2);
    chk("short len code", 32'(first_err_code), 3);
    do_reset();
    send_pkt(32'd0, 300, 256, -1, -1, '0, -1, -1, -1);
    idle(2);
    chk("bytecnt code", 32'(first_err_code), 6);
    chk("bytecnt pkt_count", pkt_count, 1);

    // SEQ wrap after resync
    do_reset();
    good_pkt(32'hFFFF_FFFE, 64);
    good_pkt(32'hFFFF_FFFF, 70);
    good_pkt(32'h0000_0000, 64);
    good_pkt(32'h0000_0001, 6);
    idle(2);
    chk("wrap err_count", err_count, 1);
    chk("wrap pkt_count", pkt_count, 4);

    // back-to-back single-beat packets, tvalid held high
    do_reset();
    for (int i = 0; i < 8; i++) begin
      good_pkt(32'(i), (i % 2) ? 64 : 6);
      chk("b2b pkt_count", pkt_count, 32'(i));
    end
    idle(2);
    chk("b2b final count", pkt_count, 8);
    chk("b2b err_count", err_count, 0);

    // reset mid-packet, then full pass with late remote_send_done
    do_reset();
    send_pkt(32'd0, 200, 200, -1, -1, '0, -1, -1, 2);
    do_reset();
    chk("midrst pkt_count", pkt_count, 0);
    chk("midrst err_count", err_count, 0);
    for (int i = 0; i < 10; i++) begin
      L = 64 + 15 * i;
      send_pkt(32'(i), L, L, -1, -1, '0, -1, (i == 9) ? 1 : -1, -1);
    end
    idle(250);
    chk("late done early valid", 32'(check_result_valid), 0);
    idle(10);
    chk("late done valid", 32'(check_result_valid), 1);
    chk("late done result", 32'(check_result), 1);
    chk("late done pkt_count", pkt_count, 10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
